// File: rtl/bit_link_pkg.sv
// Shared types and defaults for the bit-clock link.
package bit_link_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2
  } tx_state_t;

  localparam int DEFAULT_DATA_W        = 8;
  localparam int DEFAULT_CNT_W         = 16;
  localparam int DEFAULT_PREAMBLE_BITS = 16;
  localparam int MIN_BIT_PERIOD        = 1;

  // Bit-index width able to count through the longer of preamble and data.
  function automatic int idx_width(input int a, input int b);
    return (a > b) ? $clog2(a) : $clog2(b);
  endfunction

endpackage

// File: rtl/bit_stream_tx_if.sv
// Byte handshake into the serial transmitter.
interface bit_stream_tx_if import bit_link_pkg::*; #(
  parameter int DATA_W = DEFAULT_DATA_W
) ();

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/bit_timer.sv
// Per-bit cycle timer: counts 0..period and wraps, idles at 0 when disabled.
module bit_timer import bit_link_pkg::*; #(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk_200M,
  input  logic             rst,
  input  logic [CNT_W-1:0] period,
  input  logic             enable,
  output logic             bit_start,
  output logic             bit_end,
  output logic             first_half
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_200M or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!enable || cnt == period) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_start  = enable && (cnt == '0);
  assign bit_end    = enable && (cnt == period);
  assign first_half = enable && (cnt <= (period >> 1));

endmodule

// File: rtl/bit_stream_tx.sv
// NRZ frame transmitter: alternating preamble then MSB-first bytes, one-byte
// holding register, programmable bit period latched at frame start.
module bit_stream_tx import bit_link_pkg::*; #(
  parameter int DATA_W        = DEFAULT_DATA_W,
  parameter int CNT_W         = DEFAULT_CNT_W,
  parameter int PREAMBLE_BITS = DEFAULT_PREAMBLE_BITS
) (
  input  logic             clk_200M,
  input  logic             rst,
  input  logic [CNT_W-1:0] bit_period,
  bit_stream_tx_if.slave   tx,
  output logic             signal,
  output logic             tx_clk,
  output logic             bit_strobe,
  output logic             busy
);

  localparam int IDX_W = idx_width(PREAMBLE_BITS, DATA_W);
  localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PREAMBLE_BITS - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] P_MIN     = CNT_W'(MIN_BIT_PERIOD);

  tx_state_t         state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              hold_full;
  logic [DATA_W-1:0] hold_data;
  logic [DATA_W-1:0] shift;
  logic [CNT_W-1:0]  p_lat;

  logic load, shift_en, latch_p, line_nxt, busy_nxt;
  logic bit_start, bit_end, first_half;

  assign tx.tx_ready = ~hold_full;

  bit_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_200M   (clk_200M),
    .rst        (rst),
    .period     (p_lat),
    .enable     (state != IDLE),
    .bit_start  (bit_start),
    .bit_end    (bit_end),
    .first_half (first_half)
  );

  // state    | meaning
  // IDLE     | line low, waiting for a held byte to start a frame
  // PREAMBLE | sending 1,0,1,0... for PREAMBLE_BITS bits
  // DATA     | shifting out bytes MSB first, chaining while hold is refilled
  always_ff @(posedge clk_200M or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load      = 1'b0;
    shift_en  = 1'b0;
    latch_p   = 1'b0;
    line_nxt  = 1'b0;
    busy_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          latch_p   = 1'b1;
          state_nxt = PREAMBLE;
          idx_nxt   = '0;
        end
      end
      PREAMBLE: begin
        line_nxt = ~idx[0];
        busy_nxt = 1'b1;
        if (bit_end) begin
          if (idx == PRE_LAST) begin
            load      = 1'b1;
            state_nxt = DATA;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      DATA: begin
        line_nxt = shift[DATA_W-1];
        busy_nxt = 1'b1;
        if (bit_end) begin
          if (idx == DATA_LAST) begin
            idx_nxt = '0;
            if (hold_full) begin
              load = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            shift_en = 1'b1;
            idx_nxt  = idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Accept only while empty, load only while full: the two never collide.
  always_ff @(posedge clk_200M or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (tx.tx_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= tx.tx_data;
    end
  end

  always_ff @(posedge clk_200M or posedge rst) begin
    if (rst) begin
      shift <= '0;
    end else if (load) begin
      shift <= hold_data;
    end else if (shift_en) begin
      shift <= shift << 1;
    end
  end

  always_ff @(posedge clk_200M or posedge rst) begin
    if (rst) begin
      p_lat <= P_MIN;
    end else if (latch_p) begin
      p_lat <= (bit_period < P_MIN) ? P_MIN : bit_period;
    end
  end

  // Output stage keeps line edges, strobe and tx_clk rise on the same edge.
  always_ff @(posedge clk_200M or posedge rst) begin
    if (rst) begin
      signal     <= 1'b0;
      tx_clk     <= 1'b0;
      bit_strobe <= 1'b0;
      busy       <= 1'b0;
    end else begin
      signal     <= line_nxt;
      tx_clk     <= first_half;
      bit_strobe <= bit_start;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_bit_stream_tx.sv
// Directed bench for bit_stream_tx: frame shape, chaining, period handling,
// reset abort and handshake back-pressure.
`timescale 1ns/1ps
module tb_bit_stream_tx;

  localparam int PRE = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bit_period = 16'd3;
  logic        line, tx_clk, bit_strobe, busy;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_bytes [4];
  string sig_name [4] = '{"busy", "bit_strobe", "tx_clk", "signal"};

  bit_stream_tx_if #(.DATA_W(8)) tx_if ();

  bit_stream_tx #(.DATA_W(8), .CNT_W(16), .PREAMBLE_BITS(PRE)) dut (
    .clk_200M   (clk),
    .rst        (rst),
    .bit_period (bit_period),
    .tx         (tx_if),
    .signal     (line),
    .tx_clk     (tx_clk),
    .bit_strobe (bit_strobe),
    .busy       (busy)
  );

  always #2.5 clk = ~clk;

  task automatic send_byte(input logic [7:0] b, input string name);
    int n;
    n = 0;
    @(negedge clk);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = b;
    while (tx_if.tx_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: tx_ready=%b after %0d cycles, want 1", name, tx_if.tx_ready, n);
    end
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
  endtask

  // Starts at the negedge right after the accepting edge of the first byte.
  task automatic check_frame(input int nbytes, input int p, input string name);
    int len, b, t, d;
    logic e_sig;
    logic [7:0] byte_v;
    logic [3:0] got, want, got0, want0;
    int bad [4];
    int first [4];
    len = (PRE + 8 * nbytes) * (p + 1);
    got0 = '0;
    want0 = '0;
    for (int k = 0; k < 4; k++) begin
      bad[k] = 0;
      first[k] = 0;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || line !== 1'b0) begin
      errors++;
      $display("FAIL %s_latency: busy=%b signal=%b one cycle after accept, want 0 0", name, busy, line);
    end
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      b = c / (p + 1);
      t = c % (p + 1);
      if (b < PRE) begin
        e_sig = (b % 2 == 0);
      end else begin
        d = b - PRE;
        byte_v = exp_bytes[d / 8];
        e_sig = byte_v[3'(7 - d % 8)];
      end
      want = {e_sig, (t <= p / 2), (t == 0), 1'b1};
      got  = {line, tx_clk, bit_strobe, busy};
      for (int k = 0; k < 4; k++) begin
        if (got[k] !== want[k]) begin
          if (bad[k] == 0) begin
            first[k] = c;
            got0[k] = got[k];
            want0[k] = want[k];
          end
          bad[k]++;
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bad[k] != 0) begin
        errors++;
        $display("FAIL %s_%s: %0d bad cycles, first at cycle %0d got %b want %b",
                 name, sig_name[k], bad[k], first[k], got0[k], want0[k]);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || line !== 1'b0) begin
      errors++;
      $display("FAIL %s_end: busy=%b signal=%b after frame, want 0 0", name, busy, line);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({line, tx_clk, bit_strobe, busy, tx_if.tx_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_hold: outputs=%b want 00001", {line, tx_clk, bit_strobe, busy, tx_if.tx_ready});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({line, tx_clk, bit_strobe, busy, tx_if.tx_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_idle: outputs=%b want 00001", {line, tx_clk, bit_strobe, busy, tx_if.tx_ready});
    end
  endtask

  task automatic test_single_byte();
    bit_period = 16'd3;
    exp_bytes[0] = 8'hA5;
    send_byte(8'hA5, "single");
    check_frame(1, 3, "single");
  endtask

  task automatic test_back_to_back();
    bit_period = 16'd3;
    exp_bytes[0] = 8'hFF;
    exp_bytes[1] = 8'h00;
    send_byte(8'hFF, "b2b_first");
    fork
      check_frame(2, 3, "b2b");
      begin
        repeat (80) @(negedge clk);
        send_byte(8'h00, "b2b_second");
      end
    join
  endtask

  task automatic test_min_period();
    exp_bytes[0] = 8'h55;
    bit_period = 16'd0;
    send_byte(8'h55, "minp0");
    check_frame(1, 1, "minp0");
    bit_period = 16'd1;
    send_byte(8'h55, "minp1");
    check_frame(1, 1, "minp1");
  endtask

  task automatic test_period_change();
    bit_period = 16'd4;
    exp_bytes[0] = 8'h3C;
    send_byte(8'h3C, "pchg_a");
    fork
      check_frame(1, 4, "pchg_a");
      begin
        repeat (20) @(negedge clk);
        bit_period = 16'd9;
      end
    join
    exp_bytes[0] = 8'hC3;
    send_byte(8'hC3, "pchg_b");
    check_frame(1, 9, "pchg_b");
  endtask

  task automatic test_reset_mid_frame();
    int bad_line, bad_busy;
    bit_period = 16'd3;
    send_byte(8'hB5, "rstmf_a");
    repeat (70) @(negedge clk);
    send_byte(8'h77, "rstmf_b");
    checks++;
    if (tx_if.tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmf_hold: tx_ready=%b with byte held, want 0", tx_if.tx_ready);
    end
    repeat (7) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || line !== 1'b1) begin
      errors++;
      $display("FAIL rstmf_bit3: busy=%b signal=%b in data bit 3, want 1 1", busy, line);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({line, tx_clk, bit_strobe, busy, tx_if.tx_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL rstmf_async: outputs=%b during reset, want 00001", {line, tx_clk, bit_strobe, busy, tx_if.tx_ready});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad_line = 0;
    bad_busy = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (line !== 1'b0) bad_line++;
      if (busy !== 1'b0 || tx_if.tx_ready !== 1'b1) bad_busy++;
    end
    checks++;
    if (bad_line != 0) begin
      errors++;
      $display("FAIL rstmf_quiet_line: signal high on %0d cycles after reset, want 0", bad_line);
    end
    checks++;
    if (bad_busy != 0) begin
      errors++;
      $display("FAIL rstmf_quiet_busy: busy/ready wrong on %0d cycles after reset, want 0", bad_busy);
    end
    exp_bytes[0] = 8'h5A;
    send_byte(8'h5A, "rstmf_new");
    check_frame(1, 3, "rstmf_new");
  endtask

  task automatic test_handshake();
    logic [7:0] burst [4];
    bit take;
    int idx, nacc, low;
    int acc [4];
    logic [7:0] rx_byte;
    bit pre_ok;
    bit bits [$];
    burst[0] = 8'h01;
    burst[1] = 8'h80;
    burst[2] = 8'h3C;
    burst[3] = 8'hC3;
    for (int k = 0; k < 4; k++) begin
      exp_bytes[k] = burst[k];
      acc[k] = 0;
    end
    nacc = 0;
    low = 0;
    bit_period = 16'd3;
    @(negedge clk);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data = burst[0];
    @(negedge clk);
    idx = 1;
    tx_if.tx_data = burst[1];
    fork
      check_frame(4, 3, "burst");
      begin
        for (int c = 0; c < 300; c++) begin
          take = tx_if.tx_valid && tx_if.tx_ready;
          if (take) begin
            if (nacc < 4) acc[nacc] = c;
            nacc++;
          end
          if (tx_if.tx_ready !== 1'b1) low++;
          @(negedge clk);
          if (take) begin
            idx++;
            if (idx < 4) tx_if.tx_data = burst[idx];
            else tx_if.tx_valid = 1'b0;
          end
        end
      end
      begin
        for (int c = 0; c < 300; c++) begin
          @(negedge clk);
          if (bit_strobe === 1'b1) bits.push_back(line);
        end
      end
    join
    tx_if.tx_valid = 1'b0;
    checks++;
    if (nacc != 3 || acc[0] != 65 || acc[1] != 97 || acc[2] != 129) begin
      errors++;
      $display("FAIL burst_accept_times: n=%0d at %0d,%0d,%0d want n=3 at 65,97,129", nacc, acc[0], acc[1], acc[2]);
    end
    checks++;
    if (low != 158) begin
      errors++;
      $display("FAIL burst_ready_low: %0d cycles low, want 158", low);
    end
    checks++;
    if (bits.size() != PRE + 32) begin
      errors++;
      $display("FAIL burst_decoded_bits: %0d bits, want %0d", bits.size(), PRE + 32);
    end else begin
      pre_ok = 1'b1;
      for (int i = 0; i < PRE; i++) if (bits[i] != (i % 2 == 0)) pre_ok = 1'b0;
      checks++;
      if (!pre_ok) begin
        errors++;
        $display("FAIL burst_preamble: decoded preamble not 1010..., got bad pattern want alternating");
      end
      for (int k = 0; k < 4; k++) begin
        rx_byte = '0;
        for (int j = 0; j < 8; j++) rx_byte = {rx_byte[6:0], bits[PRE + 8 * k + j]};
        checks++;
        if (rx_byte !== burst[k]) begin
          errors++;
          $display("FAIL burst_byte%0d: got %h want %h", k, rx_byte, burst[k]);
        end
      end
    end
  endtask

  initial begin
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_min_period();
    test_period_change();
    test_reset_mid_frame();
    test_handshake();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200us;
    errors++;
    checks++;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
